trng_bit_collector: RTL and testbench

- Serial-to-parallel collector sitting directly behind the TRNG core.
- Samples one entropy bit (o_warbler) on each cycle the TRNG flags o_valid.
- Packs accepted bits into OUT_W-bit words and pulses byte_ready for one cycle per completed word.
- Runs a repetition-count health test on raw bits and blocks output on failure.

---
 rtl/trng_bit_collector.sv | 147 ++++++++++++++
 tb/tb_trng_bit_collector.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/trng_bit_collector.sv
// trng_bit_collector
//   Serial-to-parallel collector placed directly behind the TRNG core.
//   Accepted raw bits (enable=1 and o_valid=1) first pass a discard phase
//   of DISCARD_N bits, then are packed MSB-first into OUT_W-bit words.
//   A repetition-count health test watches every accepted raw bit; once a
//   run of REP_LIMIT identical bits is seen, health_fail latches and the
//   collector stops producing words until reset.
//
//   Optional build macro: BITCOLLECT_VON_NEUMANN_EN
//     When defined, post-discard raw bits are paired and debiased
//     (01 -> 0, 10 -> 1, 00/11 -> nothing) before being packed.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous reset, active low
//   enable      in   collection enable; 0 ignores incoming bits
//   o_valid     in   TRNG bit-valid strobe
//   o_warbler   in   TRNG entropy bit
//   byte_ready  out  one-cycle pulse when rand_byte holds a new word
//   rand_byte   out  last completed word (OUT_W bits)
//   health_fail out  sticky repetition-test failure flag

module trng_bit_collector #(
  parameter int OUT_W     = 8,
  parameter int DISCARD_N = 0,
  parameter int REP_LIMIT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             o_valid,
  input  logic             o_warbler,
  output logic             byte_ready,
  output logic [OUT_W-1:0] rand_byte,
  output logic             health_fail
);

  localparam int BIT_W  = $clog2(OUT_W) + 1;
  localparam int DISC_W = $clog2(DISCARD_N + 1) + 1;
  localparam int RUN_W  = $clog2(REP_LIMIT) + 1;

  logic [OUT_W-1:0]  r_shreg;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [DISC_W-1:0] r_disc_cnt;
  logic [RUN_W-1:0]  r_run_cnt;
  logic              r_last_bit;
  logic              r_byte_ready;
  logic [OUT_W-1:0]  r_rand_byte;
  logic              r_health_fail;

  logic              w_accept;
  logic              w_discarding;
  logic [RUN_W-1:0]  w_run_next;
  logic              w_trip;
  logic              w_coll_valid;
  logic              w_coll_bit;
  logic              w_collect;
  logic              w_word_done;
  logic [OUT_W-1:0]  w_shreg_next;

  assign w_accept = enable & o_valid;

  // The discard counter only advances while it is below DISCARD_N, so it
  // parks at DISCARD_N and inequality marks the discard phase.
  assign w_discarding = (r_disc_cnt != DISC_W'(DISCARD_N));

  // Run counter: 0 means "no bit seen yet since reset"; the first bit and
  // every change of value restart the run at 1. Saturates at REP_LIMIT.
  always_comb begin
    w_run_next = RUN_W'(1);
    if (r_run_cnt != '0 && o_warbler == r_last_bit) begin
      if (r_run_cnt == RUN_W'(REP_LIMIT))
        w_run_next = r_run_cnt;
      else
        w_run_next = r_run_cnt + RUN_W'(1);
    end
  end

  assign w_trip = w_accept & (w_run_next == RUN_W'(REP_LIMIT));

`ifdef BITCOLLECT_VON_NEUMANN_EN
  // Pair-phase state: r_pair_pend set means the first bit of a pair is held
  // in r_pair_first. A differing second bit emits the first bit's value.
  logic r_pair_pend;
  logic r_pair_first;

  assign w_coll_valid = w_accept & ~w_discarding & r_pair_pend &
                        (r_pair_first != o_warbler);
  assign w_coll_bit   = r_pair_first;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pair_pend  <= 1'b0;
      r_pair_first <= 1'b0;
    end else if (w_accept && !w_discarding) begin
      r_pair_pend <= ~r_pair_pend;
      if (!r_pair_pend)
        r_pair_first <= o_warbler;
    end
  end
`else
  assign w_coll_valid = w_accept & ~w_discarding;
  assign w_coll_bit   = o_warbler;
`endif

  // A trip on this edge suppresses the bit (and any word it would finish).
  assign w_collect    = w_coll_valid & ~r_health_fail & ~w_trip;
  assign w_word_done  = w_collect & (r_bit_cnt == BIT_W'(OUT_W - 1));
  assign w_shreg_next = {r_shreg[OUT_W-2:0], w_coll_bit};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shreg       <= '0;
      r_bit_cnt     <= '0;
      r_disc_cnt    <= '0;
      r_run_cnt     <= '0;
      r_last_bit    <= 1'b0;
      r_byte_ready  <= 1'b0;
      r_rand_byte   <= '0;
      r_health_fail <= 1'b0;
    end else begin
      r_byte_ready <= w_word_done;
      if (w_accept) begin
        r_last_bit <= o_warbler;
        r_run_cnt  <= w_run_next;
        if (w_trip)
          r_health_fail <= 1'b1;
        if (w_discarding)
          r_disc_cnt <= r_disc_cnt + DISC_W'(1);
      end
      if (w_collect) begin
        r_shreg <= w_shreg_next;
        if (w_word_done) begin
          r_bit_cnt   <= '0;
          r_rand_byte <= w_shreg_next;
        end else begin
          r_bit_cnt <= r_bit_cnt + BIT_W'(1);
        end
      end
    end
  end

  assign byte_ready  = r_byte_ready;
  assign rand_byte   = r_rand_byte;
  assign health_fail = r_health_fail;

endmodule

// File: tb/tb_trng_bit_collector.sv
module tb_trng_bit_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable, o_valid, o_warbler;
  logic       byte_ready, health_fail;
  logic [7:0] rand_byte;

  // Second instance: 4-bit words, 2 discarded bits, short repetition limit.
  logic       en2, v2, b2;
  logic       br2, hf2;
  logic [3:0] rb2;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  logic [7:0] words[$];
  int         pcyc[$];
  logic [3:0] words2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  trng_bit_collector #(.OUT_W(8), .DISCARD_N(0), .REP_LIMIT(32)) dut (
    .clk(clk), .rst(rst), .enable(enable), .o_valid(o_valid),
    .o_warbler(o_warbler), .byte_ready(byte_ready), .rand_byte(rand_byte),
    .health_fail(health_fail)
  );

  trng_bit_collector #(.OUT_W(4), .DISCARD_N(2), .REP_LIMIT(4)) dut2 (
    .clk(clk), .rst(rst), .enable(en2), .o_valid(v2),
    .o_warbler(b2), .byte_ready(br2), .rand_byte(rb2),
    .health_fail(hf2)
  );

  // Record every completed word, sampled on the falling edge.
  always @(negedge clk) begin
    if (byte_ready) begin
      words.push_back(rand_byte);
      pcyc.push_back(cyc);
    end
    if (br2) words2.push_back(rb2);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic drive(input logic v, input logic e, input logic b);
    @(negedge clk);
    o_valid = v; enable = e; o_warbler = b;
  endtask

  task automatic drive2(input logic v, input logic b);
    @(negedge clk);
    v2 = v; en2 = 1'b1; b2 = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0);
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) drive(1'b1, 1'b1, w[i]);
  endtask

  task automatic clear_log();
    words.delete();
    pcyc.delete();
  endtask

  function automatic logic [7:0] word_at(input int k);
    return (words.size() > k) ? words[k] : 8'h00;
  endfunction

  int         t_last;
  int         exp_health_pulses;
  logic [7:0] exp_health_word;

  initial begin
    rst = 1'b0; enable = 1'b0; o_valid = 1'b0; o_warbler = 1'b0;
    en2 = 1'b0; v2 = 1'b0; b2 = 1'b0;
    #3;
    check("reset byte_ready", byte_ready, 0);
    check("reset rand_byte", rand_byte, 8'h00);
    check("reset health_fail", health_fail, 0);
    @(negedge clk);
    rst = 1'b1;

`ifdef BITCOLLECT_VON_NEUMANN_EN
    begin
      logic [19:0] vn;
      vn = 20'b01101100100101101001;
      clear_log();
      for (int i = 19; i >= 0; i--) drive(1'b1, 1'b1, vn[i]);
      idle(4);
      check("vn pulse count", words.size(), 1);
      check("vn word", word_at(0), 8'h66);
    end
    exp_health_pulses = 0;
    exp_health_word   = 8'h00;
`else
    // Pattern capture with the pulse one cycle after the 8th bit.
    clear_log();
    send_word(8'hB2);
    t_last = cyc;
    idle(4);
    check("pattern pulse count", words.size(), 1);
    check("pattern word", word_at(0), 8'hB2);
    check("pattern pulse latency", (pcyc.size() > 0) ? pcyc[0] - t_last : -1, 1);
    check("pattern byte_ready low", byte_ready, 0);
    check("pattern rand_byte held", rand_byte, 8'hB2);

    // Same bits with valid gaps and an enable=0 window carrying junk bits.
    clear_log();
    drive(1, 1, 1); drive(0, 1, 0); drive(1, 1, 0); drive(1, 1, 1);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b1);
    drive(0, 1, 0);
    check("gaps no early pulse", words.size(), 0);
    drive(1, 1, 1); drive(0, 1, 1); drive(1, 1, 0); drive(1, 1, 0);
    drive(0, 1, 1); drive(1, 1, 1); drive(1, 1, 0);
    idle(4);
    check("gaps pulse count", words.size(), 1);
    check("gaps word", word_at(0), 8'hB2);

    // Back-to-back words with o_valid held high.
    clear_log();
    send_word(8'hA5);
    send_word(8'h3C);
    idle(4);
    check("b2b pulse count", words.size(), 2);
    check("b2b word0", word_at(0), 8'hA5);
    check("b2b word1", word_at(1), 8'h3C);
    check("b2b spacing", (pcyc.size() > 1) ? pcyc[1] - pcyc[0] : -1, 8);

    // Partial word before the reset below must be lost.
    drive(1, 1, 1); drive(1, 1, 1); drive(1, 1, 1);
    exp_health_pulses = 3;
    exp_health_word   = 8'hFF;
`endif

    // Asynchronous reset mid-operation with o_valid high.
    drive(1'b1, 1'b1, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("midreset byte_ready", byte_ready, 0);
    check("midreset rand_byte", rand_byte, 8'h00);
    check("midreset health_fail", health_fail, 0);
    o_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

`ifndef BITCOLLECT_VON_NEUMANN_EN
    clear_log();
    send_word(8'hB2);
    idle(3);
    check("post-reset word", word_at(0), 8'hB2);
    check("post-reset pulse count", words.size(), 1);
`endif

    // Health trip: 32 identical ones.
    clear_log();
    for (int i = 0; i < 31; i++) drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    check("health before 32nd", health_fail, 0);
    drive(1'b0, 1'b1, 1'b0);
    check("health at 32nd", health_fail, 1);
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, 1'(i % 2));
    idle(3);
    check("health pulse count", words.size(), exp_health_pulses);
    check("health sticky", health_fail, 1);
    check("health rand_byte frozen", rand_byte, exp_health_word);

    #2 rst = 1'b0;
    #1;
    check("health reset clears", health_fail, 0);
    check("health reset rand_byte", rand_byte, 8'h00);
    @(negedge clk);
    rst = 1'b1;

`ifndef BITCOLLECT_VON_NEUMANN_EN
    // Discard of 2 bits, 4-bit word, then a trip at run length 4.
    begin
      logic [5:0] seq2;
      seq2 = 6'b110110;
      words2.delete();
      for (int i = 5; i >= 0; i--) drive2(1'b1, seq2[i]);
      drive2(1'b0, 1'b0);
      drive2(1'b0, 1'b0);
      check("dut2 discard pulse count", words2.size(), 1);
      check("dut2 word", (words2.size() > 0) ? words2[0] : 4'h0, 4'h6);
      drive2(1'b1, 1'b0);
      drive2(1'b1, 1'b0);
      drive2(1'b1, 1'b0);
      check("dut2 health before trip", hf2, 0);
      drive2(1'b1, 1'b1);
      check("dut2 health at trip", hf2, 1);
      drive2(1'b1, 1'b0);
      drive2(1'b0, 1'b0);
      drive2(1'b0, 1'b0);
      check("dut2 no pulse after trip", words2.size(), 1);
    end
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
